// File: rtl/game_pkg.sv
// Shared definitions for the LED-matrix dodge game: state encoding and
// pixel indexing into the row-major frame vector.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  function automatic int pix_idx(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/player_position.sv
// Saturating player column register: load-centre has priority over moves,
// and opposing moves in the same cycle cancel.
module player_position #(
  parameter int COLS = 8,
  parameter int CW   = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_centre,
  input  logic          move_left,
  input  logic          move_right,
  output logic [CW-1:0] col
);

  localparam logic [CW-1:0] CENTRE  = CW'(COLS / 2);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  logic [CW-1:0] col_q, col_d;

  always_comb begin
    col_d = col_q;
    if (load_centre)
      col_d = CENTRE;
    else if (move_left && !move_right && col_q != '0)
      col_d = col_q - CW'(1);
    else if (move_right && !move_left && col_q != COL_MAX)
      col_d = col_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) col_q <= CENTRE;
    else     col_q <= col_d;
  end

  assign col = col_q;

endmodule

// File: rtl/dodge_game_core.sv
// Dodge game core: player/lives/score tracking with an IDLE/PLAY/HIT/OVER
// state machine and a registered composed frame for the matrix driver.
module dodge_game_core
  import game_pkg::*;
#(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int LIVES       = 3,
  parameter int SCORE_W     = 32,
  parameter int FLASH_TICKS = 4
) (
  input  logic                     system_clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     left,
  input  logic                     right,
  input  logic                     scroll_tick,
  input  logic [ROWS*COLS-1:0]     framebuffer,
  output logic [ROWS*COLS-1:0]     new_framebuffer,
  output logic [$clog2(COLS)-1:0]  player_col,
  output logic [SCORE_W-1:0]       score,
  output logic [3:0]               lives,
  output logic [1:0]               state,
  output logic                     game_over
);

  localparam int N  = ROWS * COLS;
  localparam int CW = $clog2(COLS);
  localparam int FW = $clog2(FLASH_TICKS + 1);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         lives_q, lives_d;
  logic [FW-1:0]      flash_q, flash_d;
  logic [N-1:0]       new_fb_q, new_fb_d;
  logic               game_over_q, game_over_d;

  logic               load_centre, move_en, coll, visible;
  logic [N-1:0]       pix_mask, fb_at_p;
  int                 p_idx;

  player_position #(.COLS(COLS), .CW(CW)) u_pos (
    .clk        (system_clk),
    .rst        (rst),
    .load_centre(load_centre),
    .move_left  (move_en & left),
    .move_right (move_en & right),
    .col        (player_col)
  );

  assign p_idx    = pix_idx(ROWS - 1, int'(player_col), COLS);
  assign pix_mask = {{(N-1){1'b0}}, 1'b1} << p_idx;
  assign fb_at_p  = framebuffer >> p_idx;
  assign coll     = fb_at_p[0];

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    lives_d     = lives_q;
    flash_d     = flash_q;
    load_centre = 1'b0;
    move_en     = 1'b0;
    visible     = 1'b1;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d     = ST_PLAY;
          score_d     = '0;
          lives_d     = 4'(LIVES);
          flash_d     = '0;
          load_centre = 1'b1;
        end
      end
      ST_PLAY: begin
        move_en = 1'b1;
        // A hit swallows any scroll tick in the same cycle.
        if (coll) begin
          lives_d = lives_q - 4'd1;
          if (lives_q == 4'd1) begin
            state_d = ST_OVER;
          end else begin
            state_d = ST_HIT;
            flash_d = FW'(FLASH_TICKS);
          end
        end else if (scroll_tick && score_q != '1) begin
          score_d = score_q + SCORE_W'(1);
        end
      end
      ST_HIT: begin
        move_en = 1'b1;
        visible = ~flash_q[0];
        if (scroll_tick) begin
          flash_d = flash_q - FW'(1);
          if (flash_q == FW'(1)) state_d = ST_PLAY;
        end
      end
      default: ;
    endcase
    new_fb_d    = (state_q == ST_OVER) ? '1
                : (framebuffer | (visible ? pix_mask : '0));
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge system_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      score_q     <= '0;
      lives_q     <= 4'(LIVES);
      flash_q     <= '0;
      new_fb_q    <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      flash_q     <= flash_d;
      new_fb_q    <= new_fb_d;
      game_over_q <= game_over_d;
    end
  end

  assign new_framebuffer = new_fb_q;
  assign score           = score_q;
  assign lives           = lives_q;
  assign state           = state_q;
  assign game_over       = game_over_q;

endmodule

// File: tb/tb_dodge_game_core.sv
// Directed bench for dodge_game_core: default 8x8 instance for gameplay,
// plus a 16x4 instance with a 3-bit score for geometry and saturation.
module tb_dodge_game_core;

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  // default geometry instance
  logic        rst, start, left, right, tick;
  logic [63:0] fb, nfb;
  logic [2:0]  col;
  logic [31:0] score;
  logic [3:0]  lives;
  logic [1:0]  state;
  logic        go;

  dodge_game_core u_dut (
    .system_clk(gclk), .rst(rst), .start(start), .left(left), .right(right),
    .scroll_tick(tick), .framebuffer(fb), .new_framebuffer(nfb),
    .player_col(col), .score(score), .lives(lives), .state(state),
    .game_over(go)
  );

  // 16 rows x 4 cols, 3-bit score
  logic         rst2, start2, left2, right2, tick2;
  logic [63:0]  fb2, nfb2;
  logic [1:0]   col2;
  logic [2:0]   score2;
  logic [3:0]   lives2;
  logic [1:0]   state2;
  logic         go2;

  dodge_game_core #(.ROWS(16), .COLS(4), .SCORE_W(3)) u_dut2 (
    .system_clk(gclk), .rst(rst2), .start(start2), .left(left2), .right(right2),
    .scroll_tick(tick2), .framebuffer(fb2), .new_framebuffer(nfb2),
    .player_col(col2), .score(score2), .lives(lives2), .state(state2),
    .game_over(go2)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // drive one cycle of pulses on the default instance, sample at negedge
  task automatic cyc(input logic s, input logic l, input logic r, input logic t);
    start = s; left = l; right = r; tick = t;
    @(posedge gclk); @(negedge gclk);
    start = 0; left = 0; right = 0; tick = 0;
  endtask

  task automatic cyc2(input logic s, input logic l, input logic r, input logic t);
    start2 = s; left2 = l; right2 = r; tick2 = t;
    @(posedge gclk); @(negedge gclk);
    start2 = 0; left2 = 0; right2 = 0; tick2 = 0;
  endtask

  localparam logic [63:0] B60 = 64'h1 << 60;
  localparam logic [63:0] B59 = 64'h1 << 59;

  initial begin
    rst = 1; start = 0; left = 0; right = 0; tick = 0; fb = '0;
    rst2 = 1; start2 = 0; left2 = 0; right2 = 0; tick2 = 0; fb2 = '0;
    @(negedge gclk);

    // 1: reset state, start, five ticks
    cyc(0, 0, 0, 0);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_lives", 64'(lives), 64'd3);
    chk("rst_score", 64'(score), 64'd0);
    chk("rst_col",   64'(col),   64'd4);
    chk("rst_nfb",   nfb,        64'd0);
    chk("rst_go",    64'(go),    64'd0);
    rst = 0;
    cyc(1, 0, 0, 0);
    chk("start_state", 64'(state), 64'd1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
    chk("t1_score", 64'(score), 64'd5);
    chk("t1_lives", 64'(lives), 64'd3);
    chk("t1_nfb",   nfb,        B60);

    // 2: left saturation and cancelling moves
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0);
    chk("left_sat", 64'(col), 64'd0);
    cyc(0, 1, 1, 0);
    chk("lr_hold", 64'(col), 64'd0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
    chk("back_ctr", 64'(col), 64'd4);

    // 3: hit with simultaneous tick, invulnerability and blink
    fb = B60;
    cyc(0, 0, 0, 1);
    chk("hit_lives", 64'(lives), 64'd2);
    chk("hit_state", 64'(state), 64'd2);
    chk("hit_score", 64'(score), 64'd5);
    cyc(0, 0, 0, 1);                     // flash 4 -> 3
    chk("inv_lives", 64'(lives), 64'd2);
    chk("inv_state", 64'(state), 64'd2);
    fb = 64'h1;
    cyc(0, 0, 0, 0);                     // composed with flash 3: hidden
    chk("blink_odd", nfb, 64'h1);
    cyc(0, 0, 0, 1);                     // flash 3 -> 2
    cyc(0, 0, 0, 0);                     // composed with flash 2: shown
    chk("blink_even", nfb, 64'h1 | B60);
    fb = B60;
    cyc(0, 0, 0, 1);                     // 2 -> 1
    chk("inv_state2", 64'(state), 64'd2);
    cyc(0, 0, 0, 1);                     // 1 -> 0, back to PLAY
    fb = '0;
    chk("rec_state", 64'(state), 64'd1);
    chk("rec_lives", 64'(lives), 64'd2);
    chk("rec_score", 64'(score), 64'd5);

    // 4: run out of lives, then restart
    fb = B60;
    cyc(0, 0, 0, 0);
    fb = '0;
    chk("hit2_lives", 64'(lives), 64'd1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    chk("rec2_state", 64'(state), 64'd1);
    cyc(0, 1, 0, 0);
    chk("pre3_col", 64'(col), 64'd3);
    fb = B59;
    cyc(0, 0, 0, 1);
    fb = '0;
    chk("over_lives", 64'(lives), 64'd0);
    chk("over_state", 64'(state), 64'd3);
    chk("over_go",    64'(go),    64'd1);
    cyc(0, 1, 0, 1);
    chk("over_nfb",   nfb,        '1);
    chk("over_col",   64'(col),   64'd3);
    chk("over_score", 64'(score), 64'd5);
    cyc(1, 0, 0, 0);
    chk("rs_state", 64'(state), 64'd1);
    chk("rs_lives", 64'(lives), 64'd3);
    chk("rs_score", 64'(score), 64'd0);
    chk("rs_col",   64'(col),   64'd4);
    chk("rs_go",    64'(go),    64'd0);

    // 5: reset in the middle of HIT, then IDLE pass-through
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    fb = B60;
    cyc(0, 0, 0, 0);
    fb = '0;
    chk("h5_state", 64'(state), 64'd2);
    rst = 1;
    cyc(0, 0, 0, 0);
    rst = 0;
    chk("r5_state", 64'(state), 64'd0);
    chk("r5_lives", 64'(lives), 64'd3);
    chk("r5_score", 64'(score), 64'd0);
    chk("r5_nfb",   nfb,        64'd0);
    chk("r5_go",    64'(go),    64'd0);
    fb = 64'h8;
    cyc(0, 1, 0, 0);
    chk("idle_col", 64'(col), 64'd4);
    chk("idle_nfb", nfb, 64'h8 | B60);

    // 6: 16x4 geometry and 3-bit score saturation
    cyc2(0, 0, 0, 0);
    rst2 = 0;
    chk("g_col", 64'(col2), 64'd2);
    cyc2(1, 0, 0, 0);
    chk("g_nfb_idle", nfb2, 64'h1 << 62);
    for (int i = 0; i < 9; i++) cyc2(0, 0, 0, 1);
    chk("g_score_sat", 64'(score2), 64'd7);
    cyc2(0, 0, 1, 0);
    cyc2(0, 0, 1, 0);
    chk("g_right_sat", 64'(col2), 64'd3);
    chk("g_nfb", nfb2, 64'h1 << 63);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
